// File: rtl/rom_seq_pkg.sv
// Shared types and constants for the ROM address sequencer.
package rom_seq_pkg;

    localparam int ROM_ADDR_W  = 8;
    localparam int ROM_DATA_W  = 8;
    localparam int ROM_LAT_MAX = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic                  valid;
        logic [ROM_ADDR_W:0]   index;
    } lat_entry_t;

endpackage

// File: rtl/rom_addr_sequencer_lat_pipe.sv
// Fixed-depth shift register tracking in-flight ROM reads (valid, index).
module rom_lat_pipe
    import rom_seq_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  lat_entry_t in_entry,
    output lat_entry_t out_entry,
    output logic       empty
);

    lat_entry_t stage_q [DEPTH];
    lat_entry_t stage_d [DEPTH];

    // Next-stage values: new entry at the head, everything else moves one step.
    always_comb begin
        stage_d[0] = in_entry;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Pipe storage; reset drops every in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    // Empty when no stage carries a valid read.
    always_comb begin
        empty = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (stage_q[i].valid) begin
                empty = 1'b0;
            end else begin
                empty = empty;
            end
        end
    end

    assign out_entry = stage_q[DEPTH-1];

endmodule

// File: rtl/rom_addr_sequencer.sv
// Walks base/stride/count over the ROM address space, one address per clock,
// and returns each read word with its sequence index after ROM_LAT cycles.
module rom_addr_sequencer
    import rom_seq_pkg::*;
#(
    parameter int ADDR_W  = ROM_ADDR_W,
    parameter int DATA_W  = ROM_DATA_W,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] rom_data,
    output logic              busy,
    output logic              done,
    output logic              data_valid,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W:0]   data_index
);

    // Out-of-range latencies are clamped so the pipe is always 1..ROM_LAT_MAX deep.
    localparam int PIPE_DEPTH = (ROM_LAT < 1) ? 1 :
                                (ROM_LAT > ROM_LAT_MAX) ? ROM_LAT_MAX : ROM_LAT;
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   issue_cnt_q, issue_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              data_valid_q, data_valid_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [ADDR_W:0]   data_index_q, data_index_d;

    lat_entry_t pipe_in_s;
    lat_entry_t pipe_out_s;
    logic       pipe_empty_s;

    assign pipe_in_s.valid = (state_q == ISSUE);
    assign pipe_in_s.index = (ROM_ADDR_W+1)'(issue_cnt_q);

    rom_lat_pipe #(.DEPTH(PIPE_DEPTH)) u_lat_pipe (
        .clk       (clk),
        .rst_n     (reset_n),
        .in_entry  (pipe_in_s),
        .out_entry (pipe_out_s),
        .empty     (pipe_empty_s)
    );

    // Next-state, address/issue counters and output-stage values.
    always_comb begin
        state_d     = state_q;
        address_d   = address_q;
        stride_d    = stride_q;
        count_d     = count_q;
        issue_cnt_d = issue_cnt_q;
        case (state_q)
            IDLE: begin
                if (start && (count != '0)) begin
                    state_d     = ISSUE;
                    address_d   = base_addr;
                    stride_d    = stride;
                    count_d     = count;
                    issue_cnt_d = '0;
                end else if (start) begin
                    state_d = FIN;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                // The final address is held through DRAIN and IDLE.
                if (issue_cnt_q == (count_q - CNT_ONE)) begin
                    state_d = DRAIN;
                end else begin
                    address_d   = address_q + stride_q;
                    issue_cnt_d = issue_cnt_q + CNT_ONE;
                end
            end
            DRAIN: begin
                if (pipe_empty_s) begin
                    state_d = FIN;
                end else begin
                    state_d = DRAIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d       = (state_d != IDLE);
        done_d       = (state_d == FIN);
        data_valid_d = pipe_out_s.valid;
        if (pipe_out_s.valid) begin
            data_out_d   = rom_data;
            data_index_d = (ADDR_W+1)'(pipe_out_s.index);
        end else begin
            data_out_d   = '0;
            data_index_d = '0;
        end
    end

    // FSM, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            address_q    <= '0;
            stride_q     <= '0;
            count_q      <= '0;
            issue_cnt_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            data_valid_q <= 1'b0;
            data_out_q   <= '0;
            data_index_q <= '0;
        end else begin
            state_q      <= state_d;
            address_q    <= address_d;
            stride_q     <= stride_d;
            count_q      <= count_d;
            issue_cnt_q  <= issue_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            data_valid_q <= data_valid_d;
            data_out_q   <= data_out_d;
            data_index_q <= data_index_d;
        end
    end

    assign address    = address_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign data_valid = data_valid_q;
    assign data_out   = data_out_q;
    assign data_index = data_index_q;

endmodule

// File: tb/tb_rom_addr_sequencer.sv
// Scoreboard bench: three sequencers (ROM_LAT 1..3) share stimulus; each has its
// own ROM model, expected-read queue and monitor.
module tb_rom_addr_sequencer;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] base_addr;
    logic [7:0] stride;
    logic [8:0] count;

    logic [7:0] addr_w [NI];
    logic       busy_w [NI];
    logic       done_w [NI];
    logic       dv_w   [NI];
    logic [7:0] dout_w [NI];
    logic [8:0] didx_w [NI];

    logic [7:0] mem [256];

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    int   sw_base, sw_stride, sw_count, sw_acc;
    event ev_sweep, ev_final;

    typedef struct {
        int idx;
        int data;
        int cyc;
    } exp_t;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int addr_of(input int b, input int s, input int k);
        return (b + k * s) % 256;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : gen_dut
        localparam int L = g + 1;

        logic [7:0] ra [L];
        logic [7:0] rom_data;
        exp_t exp_q[$];
        int   done_q[$];
        int   a_acc = 0, a_base = 0, a_stride = 0, a_cnt = 0, a_prev = 0;
        int   b_lo = 1, b_hi = 0;

        rom_addr_sequencer #(.ADDR_W(8), .DATA_W(8), .ROM_LAT(L)) dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .start      (start),
            .base_addr  (base_addr),
            .stride     (stride),
            .count      (count),
            .address    (addr_w[g]),
            .rom_data   (rom_data),
            .busy       (busy_w[g]),
            .done       (done_w[g]),
            .data_valid (dv_w[g]),
            .data_out   (dout_w[g]),
            .data_index (didx_w[g])
        );

        // ROM with L cycles from address to data
        always @(posedge clk) begin
            ra[0] <= addr_w[g];
            for (int i = 1; i < L; i++) ra[i] <= ra[i-1];
        end
        assign rom_data = mem[ra[L-1]];

        function automatic int exp_addr(input int c);
            if (a_cnt == 0 || c < a_acc) return a_prev;
            if (c - a_acc < a_cnt) return addr_of(a_base, a_stride, c - a_acc);
            return addr_of(a_base, a_stride, a_cnt - 1);
        endfunction

        always @(ev_sweep) begin
            a_prev   = exp_addr(sw_acc - 1);
            a_acc    = sw_acc;
            a_base   = sw_base;
            a_stride = sw_stride;
            a_cnt    = sw_count;
            for (int k = 0; k < sw_count; k++) begin
                exp_q.push_back('{k, int'(mem[addr_of(sw_base, sw_stride, k)]), sw_acc + 1 + k + L});
            end
            b_lo = sw_acc;
            b_hi = (sw_count == 0) ? sw_acc : sw_acc + sw_count + L + 1;
            done_q.push_back(b_hi);
        end

        always @(negedge reset_n) begin
            exp_q.delete();
            done_q.delete();
            a_prev = 0; a_cnt = 0; a_acc = 0;
            b_lo = 1; b_hi = 0;
        end

        always @(negedge clk) begin
            logic want_busy;
            want_busy = (cyc >= b_lo && cyc <= b_hi);
            total++;
            if (busy_w[g] !== want_busy) begin
                bad++;
                $display("FAIL busy L=%0d cyc=%0d got=%0b want=%0b", L, cyc, busy_w[g], want_busy);
            end
            total++;
            if (addr_w[g] !== 8'(exp_addr(cyc))) begin
                bad++;
                $display("FAIL address L=%0d cyc=%0d got=%02h want=%02h", L, cyc, addr_w[g], 8'(exp_addr(cyc)));
            end
            if (dv_w[g]) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_valid L=%0d cyc=%0d idx=%0d", L, cyc, didx_w[g]);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (int'(didx_w[g]) != e.idx || int'(dout_w[g]) != e.data || cyc != e.cyc) begin
                        bad++;
                        $display("FAIL read L=%0d got idx=%0d data=%02h cyc=%0d want idx=%0d data=%02h cyc=%0d",
                                 L, didx_w[g], dout_w[g], cyc, e.idx, e.data, e.cyc);
                    end
                end
            end
            if (done_w[g]) begin
                total++;
                if (done_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done L=%0d cyc=%0d", L, cyc);
                end else begin
                    int dc;
                    dc = done_q.pop_front();
                    if (cyc != dc) begin
                        bad++;
                        $display("FAIL done_cycle L=%0d got=%0d want=%0d", L, cyc, dc);
                    end
                end
            end
        end

        always @(ev_final) begin
            total++;
            if (exp_q.size() != 0 || done_q.size() != 0) begin
                bad++;
                $display("FAIL leftover L=%0d reads=%0d dones=%0d want 0 and 0", L, exp_q.size(), done_q.size());
            end
        end
    end

    task automatic note_accept(input logic [7:0] b, input logic [7:0] s, input logic [8:0] c);
        sw_base   = int'(b);
        sw_stride = int'(s);
        sw_count  = int'(c);
        sw_acc    = cyc;
        ->ev_sweep;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((busy_w[0] || busy_w[1] || busy_w[2]) && n < 1000);
        if (n >= 1000) begin
            total++;
            bad++;
            $display("FAIL idle_timeout busy still high after %0d cycles, want low", n);
        end
    endtask

    task automatic sweep(input logic [7:0] b, input logic [7:0] s, input logic [8:0] c, input bit poke);
        @(negedge clk);
        start = 1'b1; base_addr = b; stride = s; count = c;
        @(posedge clk);
        #1;
        note_accept(b, s, c);
        start = 1'b0;
        if (poke) begin
            // restart request and new operands while the sweep is running
            @(negedge clk);
            start = 1'b1; base_addr = ~b; stride = s + 8'd7; count = 9'd5;
            @(negedge clk);
            start = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; base_addr = 8'd0; stride = 8'd0; count = 9'd0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (2) @(posedge clk);

        sweep(8'h10, 8'h01, 9'd4, 1'b0);
        sweep(8'hFE, 8'h03, 9'd3, 1'b0);
        sweep(8'h22, 8'h05, 9'd0, 1'b0);
        sweep(8'h40, 8'h02, 9'd6, 1'b1);
        sweep(8'h00, 8'h01, 9'd256, 1'b0);
        sweep(8'h80, 8'h01, 9'd256, 1'b0);

        // count=0 with start held: re-accepted in the IDLE cycle after FIN
        @(negedge clk);
        start = 1'b1; base_addr = 8'h55; stride = 8'h01; count = 9'd0;
        @(posedge clk); #1; note_accept(8'h55, 8'h01, 9'd0);
        @(posedge clk); #1;
        @(posedge clk); #1; note_accept(8'h55, 8'h01, 9'd0);
        start = 1'b0;
        wait_idle();

        // reset while ROM_LAT=2 is draining
        @(negedge clk);
        start = 1'b1; base_addr = 8'h30; stride = 8'h01; count = 9'd4;
        @(posedge clk); #1; note_accept(8'h30, 8'h01, 9'd4);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            total++;
            if (addr_w[i] !== 8'd0 || busy_w[i] !== 1'b0 || done_w[i] !== 1'b0 ||
                dv_w[i] !== 1'b0 || dout_w[i] !== 8'd0 || didx_w[i] !== 9'd0) begin
                bad++;
                $display("FAIL reset_outputs inst=%0d addr=%02h busy=%0b done=%0b dv=%0b data=%02h idx=%0d want all 0",
                         i, addr_w[i], busy_w[i], done_w[i], dv_w[i], dout_w[i], didx_w[i]);
            end
        end
        @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (8) @(posedge clk);

        sweep(8'hA0, 8'h11, 9'd5, 1'b0);
        for (int r = 0; r < 10; r++) begin
            sweep(8'($urandom), 8'($urandom), 9'($urandom_range(0, 24)), 1'($urandom_range(0, 1)));
        end

        repeat (4) @(posedge clk);
        ->ev_final;
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rom_addr_sequencer.md
# rom_addr_sequencer

Stimulus-side address sequencer for the ROM DUT. On a `start` request it walks a programmable address range (base, stride, count) and drives one ROM address per clock onto the input-interface `address` signal. It also tracks the ROM read latency and returns each read word with a valid strobe and its sequence index. It sits directly upstream of the ROM input interface (master side) and feeds the response checker.

## Interface
- `ADDR_W`, 8, ROM address width; must match the interface `address` width.
- `DATA_W`, 8, ROM data width.
- `ROM_LAT`, 1, cycles from address issue to valid `rom_data`; legal range 1..4.

- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a sweep; sampled only in IDLE.
- `base_addr` in ADDR_W: first address; captured when `start` is accepted.
- `stride` in ADDR_W: address increment; captured when `start` is accepted.
- `count` in ADDR_W+1: number of reads, 0..256; captured when `start` is accepted.
- `address` out ADDR_W: ROM address, registered; connects to interface `address`.
- `rom_data` in DATA_W: ROM read data.
- `busy` out 1: high from accept until `done`.
- `done` out 1: one-cycle pulse at the end of a sweep.
- `data_valid` out 1: `data_out` and `data_index` are valid this cycle.
- `data_out` out DATA_W: registered copy of `rom_data` for the completed read.
- `data_index` out ADDR_W+1: sequence number 0..count-1 of `data_out`.

## Operation
- Reset values: all outputs 0; state IDLE; latency pipe cleared.
- States:
  - **IDLE**: `start`=1 and `count`>0 captures the operands, loads `address`←`base_addr` and issue counter←0, then goes to ISSUE. `start`=1 and `count`=0 goes to FIN with no reads.
  - **ISSUE**: one address per cycle; `address`←`address`+`stride` (mod 2^ADDR_W, wrap silently). When issue counter = count-1, go to DRAIN and hold `address`.
  - **DRAIN**: wait until the latency pipe is empty and the final `data_valid` has been emitted, then go to FIN.
  - **FIN**: `done`=1 for one cycle; go to IDLE.
- `busy` is high in ISSUE, DRAIN and FIN; low in IDLE.
- `start` outside IDLE is ignored. Operand changes after accept are ignored.
- `address` holds its last value in IDLE. It is not returned to 0.
- Latency pipe: a shift register ROM_LAT deep carrying (valid, index). An entry enters on each issue cycle and is dropped on reset.
- `count`=256 with `stride`=1 covers the full address space, wrapping 255→0 only if `base_addr`>0.
- Reset asserted mid-sweep: all outputs go to 0 immediately, in-flight reads are discarded, and no `done` is produced.

## Timing
- `start` accepted at edge T: `address`=`base_addr` and `busy`=1 from T+1.
- Address k is driven during cycle T+1+k, for k = 0..count-1.
- Read k: `rom_data` is sampled at edge T+1+k+ROM_LAT, so `data_valid`/`data_out` for index k are visible during cycle T+2+k+ROM_LAT.
- The last `data_valid` is at cycle T+1+count+ROM_LAT. `done` comes in the following cycle, and `busy` falls with it.
- `count`=0: `busy`=1 and `done`=1 in cycle T+1, `busy`=0 at T+2, no `data_valid`.
- Back-to-back sweeps: `start` held high is re-accepted in the first IDLE cycle after FIN.

## Structure
- Package `rom_seq_pkg`:
  - `seq_state_t` enum {IDLE, ISSUE, DRAIN, FIN}.
  - Constants `ROM_ADDR_W`=8, `ROM_DATA_W`=8, `ROM_LAT_MAX`=4.
  - Struct `lat_entry_t` {valid, index}.
- Sub-module `rom_lat_pipe`: parameterised ROM_LAT-deep shift register of `lat_entry_t` with async active-low clear and an `empty` output.
- Top level: FSM, address/issue counters, and the output register stage.

## Test plan
- base=0x10, stride=1, count=4, ROM_LAT=1 → addresses 0x10..0x13 on consecutive cycles; `data_valid` 4 cycles with index 0..3 and data = ROM[0x10..0x13]; single `done`.
- base=0xFE, stride=3, count=3 → addresses 0xFE, 0x01, 0x04 (wrap); indices 0..2 correct.
- count=0 → `done` one cycle after `start`, `busy` exactly one cycle, no `data_valid`, `address` unchanged.
- `start` pulsed again during ISSUE, and operands changed mid-sweep → ignored; sweep finishes with the original parameters.
- ROM_LAT=3, count=256, stride=1, base=0 → 256 valids, last at T+260; `done` at T+261; indices continuous 0..255.
- `reset_n` low for 1 cycle during DRAIN with ROM_LAT=2 → outputs 0 immediately, no `done`, no stale `data_valid` after release; a new `start` then works normally.
